// File: rtl/dbus_sram_responder_if.sv
// dbus request/response types and the bus interface between a memory-stage
// master and a memory-side responder.
//
//   dreq  : master -> responder  {valid, addr[63:0], size, strobe[7:0], data[63:0]}
//   dresp : responder -> master  {addr_ok, data_ok, data[63:0]}
//
// Modports: master drives dreq and observes dresp; slave does the reverse.

package dbus_sram_responder_pkg;

  // Access size, encoded as log2 of the byte count.
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

interface dbus_sram_responder_if;
  import dbus_sram_responder_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_sram_responder.sv
// Memory-side end of the dbus: accepts a request, waits LATENCY cycles and
// answers with one RESP cycle from an 8-byte-wide SRAM. Stores commit at the
// end of RESP under the byte strobes; illegal accesses answer with data 0,
// err high and no write.
//
// Ports:
//   clk      : clock, all state updates on the rising edge
//   reset    : asynchronous, active-high reset
//   bus      : dbus slave modport (dreq in, dresp out)
//   busy     : high while in WAIT or RESP
//   err      : high during RESP of an illegal access
//   resp_cnt : number of completed responses, wraps at 2^32

module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  dbus_sram_responder_if.slave    bus,
  output logic                    busy,
  output logic                    err,
  output logic [31:0]             resp_cnt
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  LAT  = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic [AW-1:0] idx_reg;
  logic [7:0]    strobe_reg;
  logic [63:0]   wdata_reg;
  logic          illegal_reg;
  logic [31:0]   resp_cnt_reg;
  logic          accept;

  // Decode of the live request; only consumed in the cycle it is accepted,
  // so the stored result reflects exactly the latched address and size.
  logic [63:0]   req_offset;
  logic [AW-1:0] req_idx;
  logic          req_out_of_range;
  logic          req_misaligned;
  logic          req_illegal;

  assign req_offset       = bus.dreq.addr - BASE;
  assign req_idx          = req_offset[AW+2:3];
  // The lower-bound test keeps addresses below BASE from wrapping into the array.
  assign req_out_of_range = (bus.dreq.addr < BASE) || (req_offset >= SPAN);

  always_comb begin
    req_misaligned = 1'b0;
    case (bus.dreq.size)
      MSIZE2:  req_misaligned = bus.dreq.addr[0];
      MSIZE4:  req_misaligned = |bus.dreq.addr[1:0];
      MSIZE8:  req_misaligned = |bus.dreq.addr[2:0];
      default: req_misaligned = 1'b0;
    endcase
  end

  assign req_illegal = req_out_of_range || req_misaligned;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.dreq.valid) begin
          accept     = 1'b1;
          cnt_next   = LAT;
          state_next = (LATENCY > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!bus.dreq.valid) begin
          // Master withdrew the request: drop it without a response.
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      idx_reg      <= '0;
      strobe_reg   <= 8'd0;
      wdata_reg    <= 64'd0;
      illegal_reg  <= 1'b0;
      resp_cnt_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        idx_reg     <= req_idx;
        strobe_reg  <= bus.dreq.strobe;
        wdata_reg   <= bus.dreq.data;
        illegal_reg <= req_illegal;
      end
      if (state_reg == RESP) resp_cnt_reg <= resp_cnt_reg + 32'd1;
    end
  end

  // ------------------------------------------------------------- memory
  // Eight byte-lane arrays so each strobe bit maps onto its own RAM write.
  // The read is captured on the edge entering RESP; with zero latency that
  // edge is also the acceptance edge, so the index comes straight off the bus.
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic          wr_en;
  logic [63:0]   rd_word;

  assign rd_addr = (state_reg == IDLE) ? req_idx : idx_reg;
  assign rd_en   = (state_next == RESP);
  assign wr_en   = (state_reg == RESP) && !illegal_reg;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rd_lane;

      always_ff @(posedge clk) begin
        if (wr_en && strobe_reg[gi]) lane_mem[idx_reg] <= wdata_reg[8*gi +: 8];
        if (rd_en) rd_lane <= lane_mem[rd_addr];
      end

      assign rd_word[8*gi +: 8] = rd_lane;
    end
  endgenerate

  // ------------------------------------------------------------ outputs
  // All outputs decode registered state only; nothing from dreq reaches dresp.
  assign bus.dresp.addr_ok = (state_reg == RESP);
  assign bus.dresp.data_ok = (state_reg == RESP);
  assign bus.dresp.data    = ((state_reg == RESP) && !illegal_reg) ? rd_word : 64'd0;
  assign busy              = (state_reg != IDLE);
  assign err               = (state_reg == RESP) && illegal_reg;
  assign resp_cnt          = resp_cnt_reg;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder: one instance at LATENCY=2 and one at
// LATENCY=0, driven through their bus interfaces.

module tb_dbus_sram_responder;
  import dbus_sram_responder_pkg::*;

  logic        clk;
  logic        reset;
  logic        busy_a, err_a, busy_b, err_b;
  logic [31:0] resp_cnt_a, resp_cnt_b;

  int compare_cnt;
  int mismatch_cnt;
  int exp_cnt_a;
  int exp_cnt_b;

  dbus_sram_responder_if bus_a ();
  dbus_sram_responder_if bus_b ();

  dbus_sram_responder #(.BASE(64'h8000_0000), .DEPTH(1024), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a),
    .busy(busy_a), .err(err_a), .resp_cnt(resp_cnt_a)
  );

  dbus_sram_responder #(.BASE(64'h8000_0000), .DEPTH(1024), .LATENCY(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b),
    .busy(busy_b), .err(err_b), .resp_cnt(resp_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compare_cnt++;
    if (obs !== exp) begin
      mismatch_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on instance A; lat counts edges from the
  // acceptance edge to the first cycle with data_ok (20 = timed out).
  task automatic xfer_a(input logic [63:0] a, input msize_t sz, input logic [7:0] st,
                        input logic [63:0] wd, output logic [63:0] rd,
                        output logic rerr, output int lat, output logic busy1);
    bus_a.dreq.valid  = 1'b1;
    bus_a.dreq.addr   = a;
    bus_a.dreq.size   = sz;
    bus_a.dreq.strobe = st;
    bus_a.dreq.data   = wd;
    lat   = 0;
    busy1 = 1'b0;
    while (lat < 20) begin
      tick();
      lat++;
      if (lat == 1) busy1 = busy_a;
      if (bus_a.dresp.data_ok) break;
    end
    rd   = bus_a.dresp.data;
    rerr = err_a;
    if (bus_a.dresp.data_ok) exp_cnt_a++;
    $display("[A] addr=%h size=%0d strobe=%h wdata=%h -> data=%h err=%b lat=%0d",
             a, sz, st, wd, rd, rerr, lat);
    bus_a.dreq.valid = 1'b0;
    tick();
  endtask

  task automatic xfer_b(input logic [63:0] a, input logic [7:0] st, input logic [63:0] wd,
                        output logic [63:0] rd, output int lat);
    bus_b.dreq.valid  = 1'b1;
    bus_b.dreq.addr   = a;
    bus_b.dreq.size   = MSIZE8;
    bus_b.dreq.strobe = st;
    bus_b.dreq.data   = wd;
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (bus_b.dresp.data_ok) break;
    end
    rd = bus_b.dresp.data;
    if (bus_b.dresp.data_ok) exp_cnt_b++;
    $display("[B] addr=%h strobe=%h wdata=%h -> data=%h lat=%0d", a, st, wd, rd, lat);
    bus_b.dreq.valid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic        rerr, b1, seen;
    int          lat;

    compare_cnt  = 0;
    mismatch_cnt = 0;
    exp_cnt_a    = 0;
    exp_cnt_b    = 0;
    bus_a.dreq   = '0;
    bus_b.dreq   = '0;

    // Reset held for three cycles with no traffic.
    reset = 1'b1;
    repeat (3) tick();
    check("rst_addr_ok", 64'(bus_a.dresp.addr_ok), 64'd0);
    check("rst_data_ok", 64'(bus_a.dresp.data_ok), 64'd0);
    check("rst_data",    bus_a.dresp.data, 64'd0);
    check("rst_busy",    64'(busy_a), 64'd0);
    check("rst_err",     64'(err_a), 64'd0);
    check("rst_cnt",     64'(resp_cnt_a), 64'd0);
    reset = 1'b0;
    tick();

    // Full-word write then read back.
    xfer_a(64'h8000_0010, MSIZE8, 8'hFF, 64'h1122334455667788, rd, rerr, lat, b1);
    check("wr_lat",  64'(lat), 64'd3);
    check("wr_busy", 64'(b1), 64'd1);
    check("wr_err",  64'(rerr), 64'd0);
    check("wr_cnt",  64'(resp_cnt_a), 64'd1);
    xfer_a(64'h8000_0010, MSIZE8, 8'h00, 64'd0, rd, rerr, lat, b1);
    check("rd_data", rd, 64'h1122334455667788);
    check("rd_lat",  64'(lat), 64'd3);

    // Word 0 gets a known value for the later illegal/reset checks.
    xfer_a(64'h8000_0000, MSIZE8, 8'hFF, 64'h0102030405060708, rd, rerr, lat, b1);

    // Single-byte strobe merges into the existing word.
    xfer_a(64'h8000_0010, MSIZE1, 8'h02, 64'h0000_0000_0000_AA00, rd, rerr, lat, b1);
    xfer_a(64'h8000_0010, MSIZE8, 8'h00, 64'd0, rd, rerr, lat, b1);
    check("strobe_data", rd, 64'h112233445566AA88);
    check("strobe_cnt",  64'(resp_cnt_a), 64'(exp_cnt_a));

    // Abort: valid dropped during the first WAIT cycle.
    bus_a.dreq.valid  = 1'b1;
    bus_a.dreq.addr   = 64'h8000_0010;
    bus_a.dreq.size   = MSIZE8;
    bus_a.dreq.strobe = 8'h00;
    tick();
    check("abort_busy_wait", 64'(busy_a), 64'd1);
    bus_a.dreq.valid = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (bus_a.dresp.data_ok) seen = 1'b1;
    end
    $display("[A] aborted read addr=%h data_ok_seen=%b", 64'h8000_0010, seen);
    check("abort_no_resp", 64'(seen), 64'd0);
    check("abort_idle",    64'(busy_a), 64'd0);
    check("abort_cnt",     64'(resp_cnt_a), 64'(exp_cnt_a));
    xfer_a(64'h8000_0010, MSIZE8, 8'h00, 64'd0, rd, rerr, lat, b1);
    check("after_abort_data", rd, 64'h112233445566AA88);
    check("after_abort_lat",  64'(lat), 64'd3);

    // Illegal accesses: below BASE, misaligned word, past the top of memory.
    xfer_a(64'h7FFF_FFF8, MSIZE8, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, rd, rerr, lat, b1);
    check("low_err",  64'(rerr), 64'd1);
    check("low_data", rd, 64'd0);
    check("low_lat",  64'(lat), 64'd3);
    xfer_a(64'h8000_0002, MSIZE4, 8'hFF, 64'hCAFE_CAFE_CAFE_CAFE, rd, rerr, lat, b1);
    check("misalign_err",  64'(rerr), 64'd1);
    check("misalign_data", rd, 64'd0);
    xfer_a(64'h8000_2000, MSIZE8, 8'hFF, 64'hBAD0_BAD0_BAD0_BAD0, rd, rerr, lat, b1);
    check("high_err",  64'(rerr), 64'd1);
    check("high_data", rd, 64'd0);
    xfer_a(64'h8000_0000, MSIZE8, 8'h00, 64'd0, rd, rerr, lat, b1);
    check("illegal_nowrite", rd, 64'h0102030405060708);
    check("legal_err",       64'(rerr), 64'd0);
    check("illegal_cnt",     64'(resp_cnt_a), 64'(exp_cnt_a));

    // Reset in the middle of a pending write: no write, everything cleared.
    bus_a.dreq.valid  = 1'b1;
    bus_a.dreq.addr   = 64'h8000_0000;
    bus_a.dreq.size   = MSIZE8;
    bus_a.dreq.strobe = 8'hFF;
    bus_a.dreq.data   = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    tick();
    reset = 1'b1;
    #1;
    $display("[A] reset during WAIT addr=%h", 64'h8000_0000);
    check("midrst_busy",    64'(busy_a), 64'd0);
    check("midrst_data_ok", 64'(bus_a.dresp.data_ok), 64'd0);
    check("midrst_cnt",     64'(resp_cnt_a), 64'd0);
    bus_a.dreq.valid = 1'b0;
    tick();
    reset = 1'b0;
    exp_cnt_a = 0;
    tick();
    xfer_a(64'h8000_0000, MSIZE8, 8'h00, 64'd0, rd, rerr, lat, b1);
    check("midrst_nowrite", rd, 64'h0102030405060708);
    check("midrst_cnt_after", 64'(resp_cnt_a), 64'd1);

    // Zero-latency instance: fill two words, then back-to-back reads.
    xfer_b(64'h8000_0000, 8'hFF, 64'hA0A0_A0A0_0000_0001, rd, lat);
    check("b_wr_lat", 64'(lat), 64'd1);
    xfer_b(64'h8000_0008, 8'hFF, 64'hB0B0_B0B0_0000_0002, rd, lat);
    bus_b.dreq.valid  = 1'b1;
    bus_b.dreq.addr   = 64'h8000_0000;
    bus_b.dreq.size   = MSIZE8;
    bus_b.dreq.strobe = 8'h00;
    for (int i = 0; i < 6; i++) begin
      tick();
      $display("[B] held-valid cycle %0d data_ok=%b data=%h", i, bus_b.dresp.data_ok,
               bus_b.dresp.data);
      check($sformatf("b2b_ok_%0d", i), 64'(bus_b.dresp.data_ok), 64'((i % 2) == 0));
      if ((i % 2) == 0) begin
        exp_cnt_b++;
        check($sformatf("b2b_data_%0d", i), bus_b.dresp.data,
              (((i / 2) % 2) == 1) ? 64'hB0B0_B0B0_0000_0002 : 64'hA0A0_A0A0_0000_0001);
        bus_b.dreq.addr = ((((i / 2) + 1) % 2) == 1) ? 64'h8000_0008 : 64'h8000_0000;
      end
    end
    bus_b.dreq.valid = 1'b0;
    tick();
    check("b_cnt", 64'(resp_cnt_b), 64'(exp_cnt_b));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule

// File: doc/dbus_sram_responder.md
Name: dbus_sram_responder

Overview:
- Data-bus responder: the memory-side end of the dbus protocol that the core pipeline's memory stage initiates.
- Receives dreq, models an 8-byte-wide SRAM with programmable response latency, and returns dresp.
- Used as the memory model behind the core in simulation and as a self-checking target for memory-stage verification (stalls, store strobes, hold-until-ack behaviour).

Parameters:
- BASE, 64'h8000_0000, byte address of word 0.
- DEPTH, 1024, number of 64-bit words; power of two, ≥2.
- LATENCY, 2, wait cycles between acceptance and response; 0..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- dreq  input  dbus_req_t  fields:
  - valid
  - addr[63:0]
  - size (msize_t: MSIZE1/2/4/8)
  - strobe[7:0]
  - data[63:0]
- dresp  output  dbus_resp_t  fields:
  - addr_ok
  - data_ok
  - data[63:0]
- busy  output  1  high in WAIT and RESP.
- err  output  1  one-cycle pulse coincident with data_ok for an illegal access.
- resp_cnt  output  32  count of completed responses (data_ok pulses); wraps at 2^32.

Behaviour:
- Reset: state=IDLE, wait counter=0, all dresp fields=0, busy=0, err=0, resp_cnt=0. Memory array is not cleared. Reset asserted mid-transaction aborts it; no write occurs.
- State IDLE:
  - dresp=0.
  - If dreq.valid is sampled high, latch addr/size/strobe/data, load counter=LATENCY.
  - Next state: WAIT if LATENCY>0, else RESP.
- State WAIT:
  - Counter decrements each cycle; at counter==1, next state is RESP.
  - If dreq.valid is sampled low in WAIT, abort to IDLE: no write, no response, resp_cnt unchanged.
  - Changes to dreq fields while waiting are ignored; latched values are used.
- Read data: registered on the transition into RESP from mem[index]; index=(addr-BASE)>>3.
- State RESP (exactly one cycle):
  - addr_ok=data_ok=1.
  - dresp.data = full 64-bit word; lane extraction is done by the core.
  - At the end of the RESP cycle:
    - if strobe≠0 and access is legal, byte k of the word is written from data byte k where strobe[k]=1;
    - resp_cnt increments;
    - next state is IDLE.
- Timing: data_ok is asserted exactly LATENCY+1 cycles after the IDLE cycle in which valid was first sampled. A valid held high in the RESP cycle is not re-accepted until the following IDLE cycle. Minimum spacing between two acceptances is LATENCY+2 cycles.
- Read-after-write: a read accepted after a write's RESP cycle returns the written data; no bypass is needed because the write commits before the next IDLE.
- Illegal access, evaluated on latched values:
  - addr<BASE or addr≥BASE+DEPTH*8, or
  - addr not aligned to size (MSIZE2: addr[0]; MSIZE4: addr[1:0]; MSIZE8: addr[2:0] nonzero).
  - Response: completes normally with data=0, write suppressed, err=1 during RESP.
- Address arithmetic: offset computed in 64 bits; index uses offset[log2(DEPTH)+2:3]. No wrap-around into the array for out-of-range addresses.
- err and busy are registered, state-derived outputs; no combinational path from dreq to dresp.

Test Plan:
- Reset then idle: hold reset 3 cycles, valid=0 → dresp=0, busy=0, resp_cnt=0; assert reset mid-WAIT → state IDLE, outputs 0, no write.
- Write/read, LATENCY=2: write addr 0x8000_0010, strobe 8'hFF, data 64'h1122334455667788 → data_ok on cycle 3 after acceptance, resp_cnt=1. Read same addr → data 64'h1122334455667788.
- Byte strobe: after the previous write, write data 64'hAA00 with strobe 8'h02 → read returns 64'h112233445566AA88.
- Abort: issue read, drop valid in first WAIT cycle → no data_ok, resp_cnt unchanged; next request completes normally.
- Illegal: write to 0x7FFF_FFF8, then MSIZE4 write to 0x8000_0002 → err=1 with data_ok, data=0, memory unchanged (re-read shows prior contents).
- LATENCY=0, back-to-back reads with valid held high → data_ok every 2nd cycle, each exactly 1 cycle after acceptance.
